// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared types and encodings for the execute unit: instruction
//            format codes, 5-bit ALU op encoding, M-extension op kinds and
//            the execute-unit state enum.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Instruction format codes as presented by the decode stage
    typedef logic [3:0] fmt_t;
    localparam fmt_t c_fmt_r  = 4'd0;
    localparam fmt_t c_fmt_i  = 4'd1;
    localparam fmt_t c_fmt_il = 4'd2;
    localparam fmt_t c_fmt_ie = 4'd3;
    localparam fmt_t c_fmt_s  = 4'd4;
    localparam fmt_t c_fmt_b  = 4'd5;
    localparam fmt_t c_fmt_j  = 4'd6;
    localparam fmt_t c_fmt_ji = 4'd7;
    localparam fmt_t c_fmt_u  = 4'd8;
    localparam fmt_t c_fmt_up = 4'd9;

    // Single-cycle ALU operation encoding
    typedef logic [4:0] alu_op_t;
    localparam alu_op_t c_alu_add    = 5'd0;
    localparam alu_op_t c_alu_sub    = 5'd1;
    localparam alu_op_t c_alu_and    = 5'd2;
    localparam alu_op_t c_alu_or     = 5'd3;
    localparam alu_op_t c_alu_xor    = 5'd4;
    localparam alu_op_t c_alu_sll    = 5'd5;
    localparam alu_op_t c_alu_srl    = 5'd6;
    localparam alu_op_t c_alu_slt    = 5'd7;
    localparam alu_op_t c_alu_sra    = 5'd14;
    localparam alu_op_t c_alu_sltu   = 5'd15;
    localparam alu_op_t c_alu_sll_12 = 5'd16;

    // M-extension operations, encoded as their funct3 value
    typedef enum logic [2:0] {
        M_MUL    = 3'd0,
        M_MULH   = 3'd1,
        M_MULHSU = 3'd2,
        M_MULHU  = 3'd3,
        M_DIV    = 3'd4,
        M_DIVU   = 3'd5,
        M_REM    = 3'd6,
        M_REMU   = 3'd7
    } m_kind_e;

    // Execute-unit control states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Base RV32I operation selected by funct3 alone (funct7 variants handled by caller)
    function automatic alu_op_t base_op(input logic [2:0] funct3);
        case (funct3)
            3'd0:    return c_alu_add;
            3'd1:    return c_alu_sll;
            3'd2:    return c_alu_slt;
            3'd3:    return c_alu_sltu;
            3'd4:    return c_alu_xor;
            3'd5:    return c_alu_srl;
            3'd6:    return c_alu_or;
            default: return c_alu_and;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_decode
// Brief    : Combinational decode of fmt/funct3/funct7 into an ALU op,
//            multiply/divide selects, M-op kind and an illegal flag.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [3:0] i_fmt,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output alu_op_t    o_alu_op,
    output logic       o_is_mul,
    output logic       o_is_div,
    output m_kind_e    o_m_kind,
    output logic       o_illegal
);

    // Full decode; every output has a default so no path can latch
    always_comb begin
        o_alu_op  = c_alu_add;
        o_is_mul  = 1'b0;
        o_is_div  = 1'b0;
        o_m_kind  = m_kind_e'(i_funct3);
        o_illegal = 1'b0;
        case (i_fmt)
            c_fmt_r: begin
                if (i_funct7 == 7'h01) begin
                    if (ENABLE_M) begin
                        o_is_mul = ~i_funct3[2];
                        o_is_div = i_funct3[2];
                    end else begin
                        o_illegal = 1'b1;
                    end
                end else if (i_funct3 == 3'd0 || i_funct3 == 3'd5) begin
                    // ADD/SUB and SRL/SRA are the only ops with a 0x20 variant
                    if (i_funct7 == 7'h00) begin
                        o_alu_op = base_op(i_funct3);
                    end else if (i_funct7 == 7'h20) begin
                        o_alu_op = (i_funct3 == 3'd0) ? c_alu_sub : c_alu_sra;
                    end else begin
                        o_illegal = 1'b1;
                    end
                end else begin
                    o_alu_op  = base_op(i_funct3);
                    o_illegal = (i_funct7 != 7'h00);
                end
            end
            c_fmt_i: begin
                // funct7 is imm[11:5]; it only carries meaning for the shifts
                o_alu_op = base_op(i_funct3);
                if (i_funct3 == 3'd1) begin
                    o_illegal = (i_funct7 != 7'h00);
                end else if (i_funct3 == 3'd5) begin
                    if (i_funct7 == 7'h20) begin
                        o_alu_op = c_alu_sra;
                    end else if (i_funct7 != 7'h00) begin
                        o_illegal = 1'b1;
                    end
                end
            end
            c_fmt_il, c_fmt_s, c_fmt_b, c_fmt_j, c_fmt_ji, c_fmt_up: begin
                o_alu_op = c_alu_add;
            end
            c_fmt_u: begin
                o_alu_op = c_alu_sll_12;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Multi-cycle execute unit: registered single-cycle ALU plus an
//            iterative shift-add multiplier / restoring divider sharing one
//            XLEN+1 adder. One operation in flight, valid/ready both sides.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_fmt,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal
);

    localparam int              c_sh_w = $clog2(XLEN);
    localparam logic [XLEN-1:0] c_min  = {1'b1, {(XLEN-1){1'b0}}};

    state_e            r_state;
    logic [XLEN-1:0]   r_hi;       // product high half / partial remainder
    logic [XLEN-1:0]   r_lo;       // multiplier+product low half / dividend->quotient
    logic [XLEN-1:0]   r_opb;      // multiplicand / divisor magnitude
    logic [XLEN-1:0]   r_result;
    logic [c_sh_w-1:0] r_cnt;
    m_kind_e           r_kind;
    logic              r_neg;      // negate the selected result at the end
    logic              r_illegal;

    alu_op_t           w_alu_op;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_illegal;
    m_kind_e           w_m_kind;
    logic [XLEN-1:0]   w_alu_res;
    logic [c_sh_w-1:0] w_shamt;
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_neg;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic [XLEN-1:0]   w_special;
    logic [XLEN:0]     w_add_a;
    logic [XLEN:0]     w_add_b;
    logic              w_add_cin;
    logic [XLEN+1:0]   w_add_sum;
    logic              w_div_ok;
    logic [XLEN-1:0]   w_nxt_hi;
    logic [XLEN-1:0]   w_nxt_lo;
    logic [XLEN-1:0]   w_fin_res;

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign out_result  = r_result;
    assign out_illegal = r_illegal;

    alu_op_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .i_fmt     (in_fmt),
        .i_funct3  (in_funct3),
        .i_funct7  (in_funct7),
        .o_alu_op  (w_alu_op),
        .o_is_mul  (w_is_mul),
        .o_is_div  (w_is_div),
        .o_m_kind  (w_m_kind),
        .o_illegal (w_illegal)
    );

    assign w_shamt = in_b[c_sh_w-1:0];

    // Single-cycle ALU result, registered on acceptance
    always_comb begin
        case (w_alu_op)
            c_alu_add:    w_alu_res = in_a + in_b;
            c_alu_sub:    w_alu_res = in_a - in_b;
            c_alu_and:    w_alu_res = in_a & in_b;
            c_alu_or:     w_alu_res = in_a | in_b;
            c_alu_xor:    w_alu_res = in_a ^ in_b;
            c_alu_sll:    w_alu_res = in_a << w_shamt;
            c_alu_srl:    w_alu_res = in_a >> w_shamt;
            c_alu_slt:    w_alu_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            c_alu_sra:    w_alu_res = $unsigned($signed(in_a) >>> w_shamt);
            c_alu_sltu:   w_alu_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            c_alu_sll_12: w_alu_res = in_b << 12;
            default:      w_alu_res = '0;
        endcase
    end

    // Operand signs per M op; unsigned operands are never treated as negative
    always_comb begin
        w_a_sgn = 1'b0;
        w_b_sgn = 1'b0;
        case (w_m_kind)
            M_MULH, M_DIV, M_REM: begin
                w_a_sgn = in_a[XLEN-1];
                w_b_sgn = in_b[XLEN-1];
            end
            M_MULHSU: w_a_sgn = in_a[XLEN-1];
            default:  ;
        endcase
    end

    assign w_a_mag    = w_a_sgn ? ({XLEN{1'b0}} - in_a) : in_a;
    assign w_b_mag    = w_b_sgn ? ({XLEN{1'b0}} - in_b) : in_b;
    // Remainder follows the dividend sign; everything else follows a^b
    assign w_neg      = (w_m_kind == M_REM) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);
    assign w_div_zero = (in_b == '0);
    assign w_div_ovf  = ((w_m_kind == M_DIV) || (w_m_kind == M_REM)) &&
                        (in_a == c_min) && (in_b == '1);
    // m_kind bit 1 distinguishes REM/REMU from DIV/DIVU
    assign w_special  = w_div_zero ? (w_m_kind[1] ? in_a : '1)
                                   : (w_m_kind[1] ? '0 : in_a);

    // Shared adder: add-or-skip for MUL, trial subtract for DIV
    always_comb begin
        if (r_state == S_DIV) begin
            w_add_a   = {r_hi, r_lo[XLEN-1]};
            w_add_b   = ~{1'b0, r_opb};
            w_add_cin = 1'b1;
        end else begin
            w_add_a   = {1'b0, r_hi};
            w_add_b   = r_lo[0] ? {1'b0, r_opb} : '0;
            w_add_cin = 1'b0;
        end
    end

    assign w_add_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(XLEN+1){1'b0}}, w_add_cin};
    assign w_div_ok  = w_add_sum[XLEN+1];

    // Next iteration state for whichever engine is running
    always_comb begin
        if (r_state == S_DIV) begin
            w_nxt_hi = w_div_ok ? w_add_sum[XLEN-1:0] : w_add_a[XLEN-1:0];
            w_nxt_lo = {r_lo[XLEN-2:0], w_div_ok};
        end else begin
            w_nxt_hi = w_add_sum[XLEN:1];
            w_nxt_lo = {w_add_sum[0], r_lo[XLEN-1:1]};
        end
    end

    // Half selection and sign fix-up applied on the last iteration
    always_comb begin
        case (r_kind)
            M_MUL:                     w_fin_res = w_nxt_lo;
            M_MULH, M_MULHSU, M_MULHU: w_fin_res = r_neg ?
                (~w_nxt_hi + {{(XLEN-1){1'b0}}, (w_nxt_lo == '0)}) : w_nxt_hi;
            M_DIV, M_DIVU:             w_fin_res = r_neg ? ({XLEN{1'b0}} - w_nxt_lo) : w_nxt_lo;
            default:                   w_fin_res = r_neg ? ({XLEN{1'b0}} - w_nxt_hi) : w_nxt_hi;
        endcase
    end

    // Control FSM and iteration datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opb     <= '0;
            r_result  <= '0;
            r_cnt     <= '0;
            r_kind    <= M_MUL;
            r_neg     <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            // A DONE handshake in this cycle still completes at the consumer
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_kind    <= w_m_kind;
                        r_neg     <= w_neg;
                        r_cnt     <= '0;
                        r_illegal <= w_illegal;
                        if (w_is_mul) begin
                            r_hi    <= '0;
                            r_lo    <= w_b_mag;
                            r_opb   <= w_a_mag;
                            r_state <= S_MUL;
                        end else if (w_is_div && (w_div_zero || w_div_ovf)) begin
                            r_result <= w_special;
                            r_state  <= S_DONE;
                        end else if (w_is_div) begin
                            r_hi    <= '0;
                            r_lo    <= w_a_mag;
                            r_opb   <= w_b_mag;
                            r_state <= S_DIV;
                        end else begin
                            r_result <= w_illegal ? '0 : w_alu_res;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    r_hi  <= w_nxt_hi;
                    r_lo  <= w_nxt_lo;
                    r_cnt <= r_cnt + c_sh_w'(1);
                    if (r_cnt == c_sh_w'(XLEN-1)) begin
                        r_result <= w_fin_res;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
